// File: rtl/mul_booth_seq_if.sv
// -----------------------------------------------------------------------------
// mul_booth_seq_if
// Handshake and operand/result bundle for the sequential Booth multiplier.
//   start : request, sampled on a rising edge while the multiplier is not busy
//   a, m  : 32-bit two's-complement multiplicand / multiplier
//   q     : 64-bit signed product {HI, LO}, registered
//   busy  : high while the multiply is in progress
//   done  : one-cycle pulse when q becomes valid
// master = requester (control unit / bench), slave = multiplier.
// -----------------------------------------------------------------------------
interface mul_booth_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] m;
  logic [63:0] q;
  logic        busy;
  logic        done;

  modport master (output start, a, m, input q, busy, done);
  modport slave  (input start, a, m, output q, busy, done);
endinterface

// File: rtl/mul_booth_seq.sv
// -----------------------------------------------------------------------------
// mul_booth_seq
// Sequential 32x32 signed multiplier, radix-2 Booth, one step per clock.
// Fixed latency: 32 busy cycles followed by a one-cycle done pulse; a start
// seen during the done cycle launches the next multiply back-to-back.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : mul_booth_seq_if.slave (start, a, m in; q, busy, done out)
// -----------------------------------------------------------------------------
module mul_booth_seq (
  input  logic           clock,
  input  logic           clear,
  mul_booth_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d;      // 33 bits so that -(-2^31) fits
  logic [31:0] mq_q, mq_d;        // multiplier, shifts into low product bits
  logic        qm1_q, qm1_d;      // Booth guard bit
  logic [32:0] mcand_q, mcand_d;  // sign-extended multiplicand
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] q_q, q_d;

  logic        accept;
  logic        last_step;
  logic [32:0] sum;
  logic [32:0] acc_sh;
  logic [31:0] mq_sh;
  logic        busy, done;

  // New operands are accepted from IDLE or from the single DONE cycle.
  assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
  assign last_step = (state_q == RUN) && (cnt_q == 6'd31);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.q    = q_q;

  // ---------------------------------------------------------------------------
  // Booth step: add/subtract on {mq[0], guard}, then arithmetic shift of the
  // whole {acc, mq, guard} chain right by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case ({mq_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[32], sum[32:1]};
    mq_sh  = {sum[0], mq_q[31:1]};
  end

  // Datapath next-state. q is only touched on the final step, so it keeps the
  // previous result while a new multiply runs.
  always_comb begin
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (accept) begin
      acc_d   = '0;
      mq_d    = bus.m;
      qm1_d   = 1'b0;
      mcand_d = {bus.a[31], bus.a};
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_sh;
      mq_d  = mq_sh;
      qm1_d = mq_q[0];
      cnt_d = cnt_q + 6'd1;
      if (last_step) q_d = {acc_sh[31:0], mq_sh};
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_mul_booth_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_booth_seq
// Directed bench for mul_booth_seq. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period away from the
// active rising edge.
// -----------------------------------------------------------------------------
module tb_mul_booth_seq;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mul_booth_seq_if bus ();

  mul_booth_seq dut (
    .clock (clk),
    .clear (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply and wait (bounded) for its done pulse. The operand
  // inputs are scrambled after the accepting edge to prove they were captured.
  task automatic run_op(input logic [31:0] av, input logic [31:0] mv,
                        output logic [63:0] q_obs, output int busy_n,
                        output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    q_obs  = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.m     = mv;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.m     = ~mv;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen  = 1'b1;
        q_obs = bus.q;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;   // start coincident with clear: must be ignored
    bus.a     = 32'd6;
    bus.m     = 32'd7;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.q !== 64'h0) begin
      errors++; $display("FAIL reset_q got=%h exp=%h", bus.q, 64'h0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored got busy=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_small_positive();
    logic [63:0] q_obs; int busy_n; bit seen;
    run_op(32'd6, 32'd7, q_obs, busy_n, seen);
    checks++;
    if (seen !== 1'b1 || busy_n !== 32) begin
      errors++; $display("FAIL small_latency got seen=%b busy=%0d exp seen=1 busy=32", seen, busy_n);
    end
    checks++;
    if (q_obs !== 64'h0000_0000_0000_002A) begin
      errors++; $display("FAIL small_q got=%h exp=%h", q_obs, 64'h2A);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 64'h2A) begin
      errors++; $display("FAIL small_after got done=%b busy=%b q=%h exp 0/0/%h",
                         bus.done, bus.busy, bus.q, 64'h2A);
    end
  endtask

  task automatic test_sign_mix();
    logic [63:0] q_obs; int busy_n; bit seen;
    run_op(32'hFFFF_FFFD, 32'd5, q_obs, busy_n, seen);
    checks++;
    if (!seen || q_obs !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++; $display("FAIL neg3x5 got=%h exp=%h", q_obs, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    run_op(32'd5, 32'hFFFF_FFFD, q_obs, busy_n, seen);
    checks++;
    if (!seen || q_obs !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++; $display("FAIL 5xneg3 got=%h exp=%h", q_obs, 64'hFFFF_FFFF_FFFF_FFF1);
    end
  endtask

  task automatic test_extremes();
    logic [63:0] q_obs; int busy_n; bit seen;
    run_op(32'h8000_0000, 32'h8000_0000, q_obs, busy_n, seen);
    checks++;
    if (!seen || q_obs !== 64'h4000_0000_0000_0000) begin
      errors++; $display("FAIL min_x_min got=%h exp=%h", q_obs, 64'h4000_0000_0000_0000);
    end
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, q_obs, busy_n, seen);
    checks++;
    if (!seen || q_obs !== 64'h3FFF_FFFF_0000_0001) begin
      errors++; $display("FAIL max_x_max got=%h exp=%h", q_obs, 64'h3FFF_FFFF_0000_0001);
    end
    run_op(32'h8000_0000, 32'h7FFF_FFFF, q_obs, busy_n, seen);
    checks++;
    if (!seen || q_obs !== 64'hC000_0000_8000_0000) begin
      errors++; $display("FAIL min_x_max got=%h exp=%h", q_obs, 64'hC000_0000_8000_0000);
    end
  endtask

  task automatic test_ignored_start();
    int busy_n = 0, done_n = 0, done_at = -1;
    logic [63:0] q_obs = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd6; bus.m = 32'd7;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      bus.start = (i == 10);
      if (i == 10) begin bus.a = 32'd9; bus.m = 32'd9; end
      if (i == 11) begin bus.a = 32'd1; bus.m = 32'd1; end
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; done_at = i; q_obs = bus.q; end
    end
    checks++;
    if (done_n !== 1 || done_at !== 33 || busy_n !== 32) begin
      errors++; $display("FAIL ignored_start_timing got dones=%0d at=%0d busy=%0d exp 1/33/32",
                         done_n, done_at, busy_n);
    end
    checks++;
    if (q_obs !== 64'd42 || bus.q !== 64'd42) begin
      errors++; $display("FAIL ignored_start_q got=%h held=%h exp=%h", q_obs, bus.q, 64'd42);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n = 0, done_n = 0, gaps = 0;
    int done1_at = -1, done2_at = -1;
    logic [63:0] q1 = 'x, q2 = 'x;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd2; bus.m = 32'd3;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (!bus.busy && !bus.done && i <= 66) gaps++;
      if (bus.done) begin
        done_n++;
        if (done_n == 1) begin done1_at = i; q1 = bus.q; end
        else             begin done2_at = i; q2 = bus.q; end
      end
      if (i == 33) begin bus.a = 32'hFFFF_FFFF; bus.m = 32'hFFFF_FFFF; end
      if (i == 66) bus.start = 1'b0;
    end
    checks++;
    if (done1_at !== 33 || q1 !== 64'd6) begin
      errors++; $display("FAIL b2b_first got at=%0d q=%h exp at=33 q=%h", done1_at, q1, 64'd6);
    end
    checks++;
    if (done2_at !== 66 || q2 !== 64'd1) begin
      errors++; $display("FAIL b2b_second got at=%0d q=%h exp at=66 q=%h", done2_at, q2, 64'd1);
    end
    checks++;
    if (done_n !== 2 || busy_n !== 64 || gaps !== 0) begin
      errors++; $display("FAIL b2b_busy got dones=%0d busy=%0d gaps=%0d exp 2/64/0",
                         done_n, busy_n, gaps);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] q_obs; int busy_n; bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd6; bus.m = 32'd7;
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.q !== 64'd1) begin
      errors++; $display("FAIL midop_before got busy=%b q=%h exp 1/%h", bus.busy, bus.q, 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.q !== 64'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midop_clear got q=%h busy=%b done=%b exp 0/0/0",
                         bus.q, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd2, q_obs, busy_n, seen);
    checks++;
    if (!seen || busy_n !== 32 || q_obs !== 64'd4) begin
      errors++; $display("FAIL midop_fresh got seen=%b busy=%0d q=%h exp 1/32/%h",
                         seen, busy_n, q_obs, 64'd4);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.m     = '0;
    test_reset();
    test_small_positive();
    test_sign_mix();
    test_extremes();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
